// File: rtl/sram_ctrl.sv
// Synchronous initiator for a 32K x 32 asynchronous SRAM: one word per request,
// sequenced as SETUP / STROBE / HOLD. Define SRAM_CTRL_VERIFY_EN to add write read-back checking.
module sram_ctrl #(
    parameter int WAIT_CYCLES = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        REQ,
    output logic        RDY,
    input  logic        RW,
    input  logic [0:14] ADDR,
    input  logic [0:31] WDATA,
    output logic [0:31] RDATA,
    output logic        RVALID,
    output logic        ERR,
    output logic [0:14] A,
    inout  wire  [0:31] IO,
    output logic        CS,
    output logic        OE,
    output logic        WE,
    output logic [2:0]  o_dbg_state
);

    // Request port: a request transfers on a rising CLK edge where REQ && RDY.
    // RW/ADDR/WDATA are captured on that edge; RDY stays low until the cycle ends.
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SETUP   = 3'd1,
        S_STROBE  = 3'd2,
        S_HOLD    = 3'd3
`ifdef SRAM_CTRL_VERIFY_EN
        ,
        S_VGAP    = 3'd4,
        S_VSETUP  = 3'd5,
        S_VSTROBE = 3'd6,
        S_VHOLD   = 3'd7
`endif
    } state_t;

    localparam logic [3:0] STROBE_LOAD = 4'(WAIT_CYCLES - 1);

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_cnt;
    logic        r_rw;
    logic [0:31] r_wdata;
    logic [0:14] r_addr;
    logic [0:31] r_rdata;
    logic        r_in_rst;
    logic        w_drive;
    logic        w_accept;
    logic        w_cnt_zero;

    assign w_accept   = REQ && RDY;
    assign w_cnt_zero = (r_cnt == 4'd0);

    // State register and datapath registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state  <= S_IDLE;
            r_cnt    <= 4'd0;
            r_rw     <= 1'b0;
            r_wdata  <= '0;
            r_addr   <= '0;
            r_rdata  <= '0;
            r_in_rst <= 1'b1;
        end else begin
            r_state  <= w_next;
            r_in_rst <= 1'b0;
            if (w_accept) begin
                r_rw    <= RW;
                r_wdata <= WDATA;
                r_addr  <= ADDR;
            end
            // Counter reloads on every entry to a strobe phase and counts down to 0.
`ifdef SRAM_CTRL_VERIFY_EN
            if ((w_next == S_STROBE && r_state != S_STROBE) ||
                (w_next == S_VSTROBE && r_state != S_VSTROBE))
                r_cnt <= STROBE_LOAD;
`else
            if (w_next == S_STROBE && r_state != S_STROBE)
                r_cnt <= STROBE_LOAD;
`endif
            else if (!w_cnt_zero)
                r_cnt <= r_cnt - 4'd1;
            if (r_state == S_STROBE && w_cnt_zero && !r_rw)
                r_rdata <= IO;
        end
    end

`ifdef SRAM_CTRL_VERIFY_EN
    logic r_err;

    always_ff @(posedge CLK) begin
        if (RST)
            r_err <= 1'b0;
        else if (r_state == S_VSTROBE && w_cnt_zero && (IO != r_wdata))
            r_err <= 1'b1;
    end

    assign ERR = r_err;
`else
    assign ERR = 1'b0;
`endif

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (w_accept) w_next = S_SETUP;
            S_SETUP:   w_next = S_STROBE;
            S_STROBE:  if (w_cnt_zero) w_next = S_HOLD;
`ifdef SRAM_CTRL_VERIFY_EN
            S_HOLD:    w_next = r_rw ? S_VGAP : S_IDLE;
            S_VGAP:    w_next = S_VSETUP;
            S_VSETUP:  w_next = S_VSTROBE;
            S_VSTROBE: if (w_cnt_zero) w_next = S_VHOLD;
            S_VHOLD:   w_next = S_IDLE;
`else
            S_HOLD:    w_next = S_IDLE;
`endif
            default:   w_next = S_IDLE;
        endcase
    end

    // Output decode; VGAP keeps CS high for a cycle between the write and its read-back.
    always_comb begin
        RDY     = 1'b0;
        CS      = 1'b1;
        OE      = 1'b1;
        WE      = 1'b1;
        RVALID  = 1'b0;
        w_drive = 1'b0;
        case (r_state)
            S_IDLE:    RDY = !r_in_rst && !RST;
            S_SETUP: begin
                CS = 1'b0;
                if (r_rw) w_drive = 1'b1;
                else      OE      = 1'b0;
            end
            S_STROBE: begin
                CS = 1'b0;
                if (r_rw) begin
                    WE      = 1'b0;
                    w_drive = 1'b1;
                end else begin
                    OE = 1'b0;
                end
            end
            S_HOLD: begin
                if (r_rw) begin
                    CS      = 1'b0;
                    w_drive = 1'b1;
                end else begin
                    RVALID = 1'b1;
                end
            end
`ifdef SRAM_CTRL_VERIFY_EN
            S_VSETUP, S_VSTROBE: begin
                CS = 1'b0;
                OE = 1'b0;
            end
`endif
            default: ;
        endcase
    end

    assign IO          = w_drive ? r_wdata : 'z;
    assign A           = r_addr;
    assign RDATA       = r_rdata;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_sram_ctrl.sv
// Self-checking bench for sram_ctrl: SRAM behavioural model, golden memory,
// per-cycle bus expectations from cycle offsets after acceptance.
module tb_sram_ctrl;
    localparam int W = 2;
`ifdef SRAM_CTRL_VERIFY_EN
    localparam bit VERIFY = 1'b1;
`else
    localparam bit VERIFY = 1'b0;
`endif
    localparam logic [31:0] BUS_FLOAT = 32'hFFFF_FFFF;

    logic        CLK = 1'b0;
    logic        RST, REQ, RW;
    logic [0:14] ADDR;
    logic [0:31] WDATA;
    logic [0:31] RDATA;
    logic        RVALID, ERR, RDY, CS, OE, WE;
    logic [0:14] A;
    wire  [0:31] IO;
    logic [2:0]  dbg_state;

    sram_ctrl #(.WAIT_CYCLES(W)) dut (
        .CLK(CLK), .RST(RST), .REQ(REQ), .RDY(RDY), .RW(RW), .ADDR(ADDR),
        .WDATA(WDATA), .RDATA(RDATA), .RVALID(RVALID), .ERR(ERR), .A(A),
        .IO(IO), .CS(CS), .OE(OE), .WE(WE), .o_dbg_state(dbg_state)
    );

    // clock / reset block
    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // Released bus floats high so a stray driver shows up as a value change.
    for (genvar g = 0; g < 32; g++) begin : g_pu
        pullup (IO[g]);
    end

    // SRAM model and golden memory
    logic [31:0] mem     [0:32767];
    logic [31:0] ref_mem [0:32767];
    bit          corrupt = 1'b0;

    assign IO = (!CS && !OE && WE) ? mem[A] : 32'bz;

    always @(posedge WE) begin
        if (!CS) mem[A] <= IO ^ {31'b0, corrupt};
    end

    // scoreboard
    logic [31:0] exp_q[$];
    int          n_pass = 0;
    int          n_total = 0;
    bit          exp_err = 1'b0;
    bit          have_prev = 1'b0;
    int          prev_acc = 0;
    int          prev_p = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h (cycle %0d)", tag, got, exp, cyc);
    endtask

    function automatic int period(input bit rw);
        return (VERIFY && rw) ? 2 * W + 6 : W + 3;
    endfunction

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b1;
        REQ = 1'b0;
        @(negedge CLK);
        check("rst_cs", CS, 1);
        check("rst_oe", OE, 1);
        check("rst_we", WE, 1);
        check("rst_io", IO, BUS_FLOAT);
        check("rst_a", A, 0);
        check("rst_rdata", RDATA, 0);
        check("rst_rvalid", RVALID, 0);
        check("rst_err", ERR, 0);
        check("rst_rdy", RDY, 0);
        @(negedge CLK);
        check("rst_rdy2", RDY, 0);
        RST = 1'b0;
        @(negedge CLK);
        check("rst_rdy_release", RDY, 1);
        have_prev = 1'b0;
        exp_err = 1'b0;
        exp_q.delete();
    endtask

    // driver: called at a negedge, returns at the negedge of the first IDLE cycle
    task automatic do_txn(input bit rw, input logic [14:0] addr, input logic [31:0] data,
                          input bit keep_req);
        int p, waited;
        bit s, stb, hold, vs, vstb, cs_e, oe_e, we_e, rv_e;
        logic [31:0] io_e;
        REQ = 1'b1; RW = rw; ADDR = addr; WDATA = data;
        waited = 0;
        while (!RDY && waited < 40) begin
            @(negedge CLK);
            waited++;
        end
        if (!RDY) begin
            check("accept_timeout", {31'b0, RDY}, 1);
            REQ = 1'b0;
            return;
        end
        if (have_prev) check("req_period", cyc - prev_acc, prev_p);
        p = period(rw);
        prev_acc = cyc; prev_p = p; have_prev = 1'b1;
        if (rw) begin
            ref_mem[addr] = data ^ {31'b0, corrupt};
            if (VERIFY && corrupt) exp_err = 1'b1;
        end else begin
            exp_q.push_back(ref_mem[addr]);
        end
        @(posedge CLK);
        for (int k = 1; k <= p; k++) begin
            @(negedge CLK);
            if (k == 1) begin
                if (!keep_req) REQ = 1'b0;
                RW = 1'($urandom); ADDR = 15'($urandom); WDATA = $urandom;
            end
            s    = (k == 1);
            stb  = (k >= 2 && k <= W + 1);
            hold = (k == W + 2);
            vs   = VERIFY && rw && (k == W + 4);
            vstb = VERIFY && rw && (k >= W + 5 && k <= 2 * W + 4);
            cs_e = !(s || stb || (hold && rw) || vs || vstb);
            oe_e = !((!rw && (s || stb)) || vs || vstb);
            we_e = !(rw && stb);
            rv_e = !rw && hold;
            if (rw && (s || stb || hold)) io_e = data;
            else if (!oe_e)               io_e = ref_mem[addr];
            else                          io_e = BUS_FLOAT;
            check("cs", CS, cs_e);
            check("oe", OE, oe_e);
            check("we", WE, we_e);
            check("io", IO, io_e);
            check("rvalid", RVALID, rv_e);
            check("rdy", RDY, k == p);
            if (!cs_e) check("addr", A, addr);
            if (rv_e) check("rdata", RDATA, exp_q.pop_front());
            if (k == p) check("err", ERR, exp_err);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] v;
        for (int i = 0; i < 32768; i++) begin
            v = $urandom;
            mem[i] = v;
            ref_mem[i] = v;
        end
        RST = 1'b1; REQ = 1'b0; RW = 1'b0; ADDR = '0; WDATA = '0;
        do_reset();

        do_txn(1'b1, 15'h0000, 32'h0000_0001, 1'b0);
        REQ = 1'b0;
        check("mem0", mem[0], 32'h0000_0001);

        do_txn(1'b1, 15'h7FFF, 32'hDEAD_BEEF, 1'b0);
        do_txn(1'b0, 15'h7FFF, 32'h0, 1'b0);
        REQ = 1'b0;
        check("mem7fff", mem[15'h7FFF], 32'hDEAD_BEEF);

        for (int i = 0; i < 4; i++)
            do_txn(!i[0], 15'(3 + i / 2), $urandom, 1'b1);
        REQ = 1'b0;

        for (int i = 0; i < 24; i++)
            do_txn(1'($urandom), 15'($urandom_range(0, 7)), $urandom,
                   1'($urandom_range(0, 1)));
        REQ = 1'b0;

        // write aborted by reset in its first STROBE cycle
        have_prev = 1'b0;
        REQ = 1'b1; RW = 1'b1; ADDR = 15'h1234; WDATA = $urandom;
        @(posedge CLK);
        @(negedge CLK);
        REQ = 1'b0;
        check("abort_setup_cs", CS, 0);
        @(negedge CLK);
        check("abort_strobe_we", WE, 0);
        RST = 1'b1;
        @(negedge CLK);
        check("abort_we", WE, 1);
        check("abort_cs", CS, 1);
        check("abort_oe", OE, 1);
        check("abort_io", IO, BUS_FLOAT);
        check("abort_rvalid", RVALID, 0);
        check("abort_err", ERR, 0);
        check("abort_rdy", RDY, 0);
        RST = 1'b0;
        @(negedge CLK);
        check("abort_rdy_release", RDY, 1);
        check("abort_rvalid2", RVALID, 0);
        exp_q.delete();

        do_txn(1'b0, 15'h0000, 32'h0, 1'b0);
        REQ = 1'b0;

`ifdef SRAM_CTRL_VERIFY_EN
        do_reset();
        corrupt = 1'b1;
        do_txn(1'b1, 15'h0005, 32'h1234_5678, 1'b0);
        corrupt = 1'b0;
        do_txn(1'b1, 15'h0006, $urandom, 1'b0);
        REQ = 1'b0;
        check("err_sticky", ERR, 1);
        do_reset();
        do_txn(1'b1, 15'h0006, $urandom, 1'b0);
        do_txn(1'b0, 15'h0006, 32'h0, 1'b0);
        REQ = 1'b0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
